// File: rtl/wave_dac_pkg.sv
// Shared constants and helpers for the PWM audio DAC.
// Sample format conversion lives here so producers can reuse it.
package wave_dac_pkg;
  localparam int PWM_BITS = 12;
  localparam int PWM_PERIOD = 4096;
  localparam logic [PWM_BITS-1:0] DUTY_RESET = 12'h800;

  function automatic logic [PWM_BITS-1:0] to_offset_binary(
    input logic [PWM_BITS-1:0] s,
    input logic signed_in
  );
    return signed_in ? {~s[PWM_BITS-1], s[PWM_BITS-2:0]} : s;
  endfunction
endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO; a push is accepted when full only if
// a pop happens in the same cycle. Pops on empty are ignored.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic wr_en, rd_en;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign rdata = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr_en) wp <= wp + 1'b1;
      if (rd_en) rp <= rp + 1'b1;
      unique case (1'b1)
        wr_en & ~rd_en: count <= count + 1'b1;
        rd_en & ~wr_en: count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/wave_pwm_dac.sv
// PWM DAC sink: buffers 12-bit samples, loads one duty per
// 4096-cycle period and reports sticky overflow/underflow.
module wave_pwm_dac
  import wave_dac_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter bit SIGNED_IN  = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [11:0]                 sample,
  input  logic                        sample_valid,
  input  logic                        clear_flags,
  output logic                        pwm_out,
  output logic                        period_start,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        underflow
);
  logic [PWM_BITS-1:0] cnt, duty, conv, head;
  logic full, empty, last, pop_ok;
  logic ovf_set, unf_set;

  assign conv    = to_offset_binary(sample, SIGNED_IN);
  assign last    = (cnt == PWM_BITS'(PWM_PERIOD - 1));
  assign pop_ok  = last & ~empty;
  assign ovf_set = sample_valid & full & ~pop_ok;
  assign unf_set = last & empty;

  sample_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(PWM_BITS)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (sample_valid),
    .wdata(conv),
    .pop  (last),
    .rdata(head),
    .full (full),
    .empty(empty),
    .count(fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      duty         <= DUTY_RESET;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      cnt          <= cnt + 1'b1;
      if (pop_ok) duty <= head;
      pwm_out      <= (cnt < duty);
      period_start <= last;
      // a set in the same cycle as a clear must win
      overflow     <= ovf_set | (overflow & ~clear_flags);
      underflow    <= unf_set | (underflow & ~clear_flags);
    end
  end
endmodule

// File: tb/tb_wave_pwm_dac.sv
// Directed bench for wave_pwm_dac: period high times, FIFO
// occupancy, sticky flags and mid-period reset.
module tb_wave_pwm_dac;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic        clear_flags = 1'b0;
  logic        pwm_out, period_start, overflow, underflow;
  logic [2:0]  fifo_count;
  int n_vec = 0;
  int n_err = 0;

  wave_pwm_dac #(
    .FIFO_DEPTH(4),
    .SIGNED_IN (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample      (sample),
    .sample_valid(sample_valid),
    .clear_flags (clear_flags),
    .pwm_out     (pwm_out),
    .period_start(period_start),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [11:0] s);
    sample = s;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
  endtask

  task automatic wait_ps();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 5000 && !hit; i++) begin
      @(negedge clk);
      hit = period_start;
    end
    check("ps_wait", {31'd0, hit}, 1);
  endtask

  // Called on the period_start cycle; counts one full period of
  // pwm_out and can strobe a sample on the cnt==4095 cycle.
  task automatic measure(input int exp_hi, input bit push_last,
                         input logic [11:0] pv, input string tag);
    int hi, mid;
    hi = 0;
    mid = 0;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      hi += int'(pwm_out);
      if (i < 4095 && period_start) mid++;
      if (i == 4094 && push_last) begin
        sample = pv;
        sample_valid = 1'b1;
      end else begin
        sample_valid = 1'b0;
      end
    end
    check(tag, hi, exp_hi);
    check({tag, "_mid"}, mid, 0);
    check({tag, "_ps"}, {31'd0, period_start}, 1);
  endtask

  initial begin
    repeat (3) step();
    check("rst_pwm", {31'd0, pwm_out}, 0);
    check("rst_ps", {31'd0, period_start}, 0);
    check("rst_fc", {29'd0, fifo_count}, 0);
    check("rst_ovf", {31'd0, overflow}, 0);
    check("rst_unf", {31'd0, underflow}, 0);
    rst_n = 1'b1;
    repeat (10) step();
    check("unf_pre", {31'd0, underflow}, 0);
    wait_ps();
    check("unf_idle", {31'd0, underflow}, 1);
    measure(2048, 1'b0, 12'h0, "idle1");
    measure(2048, 1'b0, 12'h0, "idle2");
    measure(2048, 1'b0, 12'h0, "idle3");

    pulse_clear();
    check("unf_clr", {31'd0, underflow}, 0);
    push(12'h800);
    push(12'h000);
    push(12'h7FF);
    check("fc3", {29'd0, fifo_count}, 3);
    wait_ps();
    check("fc2", {29'd0, fifo_count}, 2);
    measure(0, 1'b0, 12'h0, "s800");
    check("fc1", {29'd0, fifo_count}, 1);
    measure(2048, 1'b0, 12'h0, "s000");
    check("fc0", {29'd0, fifo_count}, 0);
    measure(4095, 1'b0, 12'h0, "s7ff");
    check("ovf_s", {31'd0, overflow}, 0);

    pulse_clear();
    for (int k = 0; k < 5; k++) push(12'h100 + 12'(k));
    check("ovf_set", {31'd0, overflow}, 1);
    check("fc_full", {29'd0, fifo_count}, 4);
    pulse_clear();
    check("ovf_clr", {31'd0, overflow}, 0);
    sample = 12'h1FF;
    sample_valid = 1'b1;
    clear_flags = 1'b1;
    step();
    sample_valid = 1'b0;
    clear_flags = 1'b0;
    check("ovf_clr_set", {31'd0, overflow}, 1);
    check("fc_drop", {29'd0, fifo_count}, 4);
    pulse_clear();
    check("ovf_clr2", {31'd0, overflow}, 0);

    wait_ps();
    check("fc_pop", {29'd0, fifo_count}, 3);
    sample = 12'h105;
    sample_valid = 1'b1;
    measure(2304, 1'b1, 12'h106, "d100");
    check("fc_full_pop", {29'd0, fifo_count}, 4);
    check("ovf_full_pop", {31'd0, overflow}, 0);
    measure(2305, 1'b0, 12'h0, "d101");
    measure(2306, 1'b0, 12'h0, "d102");
    measure(2307, 1'b0, 12'h0, "d103");
    measure(2309, 1'b0, 12'h0, "d105");
    check("fc_last", {29'd0, fifo_count}, 0);
    check("unf_pre2", {31'd0, underflow}, 0);

    measure(2310, 1'b1, 12'h200, "d106");
    check("unf_push", {31'd0, underflow}, 1);
    check("fc_unf", {29'd0, fifo_count}, 1);
    measure(2310, 1'b0, 12'h0, "d106_hold");
    check("fc_unf0", {29'd0, fifo_count}, 0);
    measure(2560, 1'b0, 12'h0, "d200");

    push(12'h300);
    push(12'h301);
    check("fc_rst_pre", {29'd0, fifo_count}, 2);
    repeat (998) step();
    check("pwm_rst_pre", {31'd0, pwm_out}, 1);
    rst_n = 1'b0;
    #1;
    check("pwm_rst", {31'd0, pwm_out}, 0);
    check("fc_rst", {29'd0, fifo_count}, 0);
    check("unf_rst", {31'd0, underflow}, 0);
    check("ps_rst", {31'd0, period_start}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    measure(2048, 1'b0, 12'h0, "post_rst");
    check("unf_post", {31'd0, underflow}, 1);
    check("fc_post", {29'd0, fifo_count}, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wave_pwm_dac.md
Name: wave_pwm_dac

Overview:
- Sink end of the synthesiser sample stream: consumes 12-bit samples strobed by the wave generator's final enable and drives a 1-bit PWM pin to the board's RC audio filter.
- Samples are buffered in a small FIFO and consumed one per PWM period.
- There is no backpressure. The producer is strobe-only.
- Overflow and underflow are reported as sticky flags for CPU MMIO readback.

Parameters:
- FIFO_DEPTH, 4, sample buffer entries; power of two, 2..16.
- SIGNED_IN, 1, 1 = input is two's complement (MSB inverted to offset binary); 0 = input already unsigned.

Ports:
- clk  input  1  system clock (CPU clock domain).
- rst_n  input  1  asynchronous, active-low reset.
- sample  input  12  wave sample from synth chain.
- sample_valid  input  1  single-cycle strobe; sample is valid this cycle.
- clear_flags  input  1  synchronous pulse; clears overflow and underflow.
- pwm_out  output  1  registered PWM output.
- period_start  output  1  one-cycle pulse on the cycle a new duty value takes effect.
- fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky; a sample was dropped.
- underflow  output  1  sticky; a period started with an empty FIFO.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - cnt=0, duty=12'h800 (midscale), FIFO empty.
  - pwm_out=0, period_start=0, fifo_count=0, overflow=0, underflow=0.
- Period counter cnt:
  - 12-bit, increments every cycle and wraps 4095 -> 0.
  - PWM period is 4096 clk cycles. No enable; the counter free-runs after reset.
- Conversion: conv = SIGNED_IN ? {~sample[11], sample[10:0]} : sample.
  - Example: signed 12'h800 (-2048) -> 0; 12'h000 -> 2048; 12'h7FF -> 4095.
- Push: on sample_valid, conv is written at the write pointer if the FIFO is not full.
- Pop: occurs on the cycle cnt==4095.
  - If the FIFO is non-empty, duty <= head entry and the head is popped.
  - If empty, duty holds its previous value and underflow <= 1.
  - period_start=1 on the following cycle (cnt==0), coinciding with the first cycle using the new duty.
- Simultaneous push and pop:
  - Both occur; occupancy is unchanged.
  - When full, a push coinciding with a pop is accepted; no overflow.
  - When empty, a push coinciding with a pop does NOT bypass: the pop sees empty, underflow is set, and the sample is stored.
- Push when full without a pop: the sample is dropped, overflow <= 1, and FIFO contents are unchanged.
- PWM output:
  - pwm_out <= (cnt < duty), registered, one cycle latency from cnt.
  - duty=0 gives constant 0.
  - duty=4095 gives high for 4095 of 4096 cycles.
- Flags:
  - Sticky until clear_flags.
  - If clear_flags coincides with a new set event, the set wins (flag stays 1).
- fifo_count reflects occupancy after the current cycle's push/pop (registered).
- Pointers wrap modulo FIFO_DEPTH. Full/empty are derived from the extra pointer MSB.
- Reset asserted mid-period:
  - All state returns to reset values immediately and pwm_out drops to 0.
  - Buffered samples are discarded.

Decomposition:
- Package wave_dac_pkg: PWM_BITS=12, PWM_PERIOD=4096, DUTY_RESET=12'h800, and a function to_offset_binary(sample, signed_in).
- Sub-module sample_fifo (sync FIFO: push/pop/full/empty/count, parameter DEPTH, WIDTH=12). The top holds only the counter, duty register, PWM compare and flags.

Test Plan:
- Reset then idle for 3 periods:
  - pwm_out high exactly 2048 cycles per period (midscale).
  - underflow=1 after the first cnt==4095.
  - period_start pulses every 4096 cycles.
- SIGNED_IN=1, push 12'h800, 12'h000, 12'h7FF before the first period ends:
  - Successive periods show high times 0, 2048, 4095.
  - fifo_count goes 3,2,1,0; overflow stays 0.
- Push 5 samples (0x100..0x104) back-to-back with FIFO_DEPTH=4, no pop in between:
  - overflow=1 and fifo_count=4.
  - Played duties are offset-binary of 0x100..0x103; 0x104 is lost.
- FIFO full, sample_valid asserted exactly on the cnt==4095 cycle:
  - Pop and push both occur, fifo_count stays 4, overflow stays 0.
- FIFO empty, sample_valid on the cnt==4095 cycle:
  - underflow=1, duty unchanged, fifo_count=1.
  - The sample plays in the next period.
- Assert rst_n low at cnt=1000 with 2 samples buffered:
  - pwm_out=0 and fifo_count=0 immediately.
  - After release, cnt restarts at 0 with duty 0x800.
- clear_flags while overflow=1 and no new event: flag -> 0 next cycle.
- clear_flags coincident with an overflow event: flag stays 1.
